// File: rtl/axis_output_pipe.sv
// Buffers the convolution engine's parallel result blocks in a two-slot
// ping-pong store and replays them as an AXI-Stream, one core per beat.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_valid         single-cycle strobe: a result block is on s_data
//   s_data          block, [core][unit] words
//   s_last, s_user  block end-of-frame flag and sideband
//   s_ready         a slot is free (advisory; the engine never stalls)
//   m_axis_*        AXI-Stream master, CONV_UNITS words per beat,
//                   unit 0 in the LSBs
//   overflow        sticky: a block arrived with both slots occupied
module axis_output_pipe #(
    parameter int CONV_CORES  = 24,
    parameter int CONV_UNITS  = 8,
    parameter int WORD_WIDTH  = 25,
    parameter int TUSER_WIDTH = 4
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,

    input  logic                                  s_valid,
    input  logic [CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] s_data,
    input  logic                                  s_last,
    input  logic [TUSER_WIDTH-1:0]                s_user,
    output logic                                  s_ready,

    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [CONV_UNITS*WORD_WIDTH-1:0]      m_axis_tdata,
    output logic                                  m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]                m_axis_tuser,

    output logic                                  overflow
);

    localparam int IW = (CONV_CORES > 1) ? $clog2(CONV_CORES) : 1;
    localparam logic [IW-1:0] LAST_CORE = IW'(CONV_CORES - 1);

    // Occupancy of the ping-pong store.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    typedef logic [CONV_CORES-1:0][CONV_UNITS-1:0][WORD_WIDTH-1:0] block_t;

    fill_e                  count;
    fill_e                  count_nxt;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [IW-1:0]          core_idx;

    block_t                 slot_data [2];
    logic                   slot_last [2];
    logic [TUSER_WIDTH-1:0] slot_user [2];

    logic                   accept;
    logic                   drop;
    logic                   beat;
    logic                   last_core;
    logic                   retire;

    // Handshake flags come from the registered occupancy only, so
    // neither s_valid nor m_axis_tready reaches an output combinationally.
    assign s_ready       = (count != FULL);
    assign m_axis_tvalid = (count != EMPTY);

    assign accept    = s_valid & s_ready;
    assign drop      = s_valid & ~s_ready;
    assign beat      = m_axis_tvalid & m_axis_tready;
    assign last_core = (core_idx == LAST_CORE);
    assign retire    = beat & last_core;

    // Occupancy next-state. An accept and a retire in the same cycle
    // cancel out; FULL cannot accept because s_ready is low there.
    always_comb begin
        count_nxt = count;
        unique case (count)
            EMPTY: begin
                if (accept)
                    count_nxt = ONE;
            end
            ONE: begin
                if (accept && !retire)
                    count_nxt = FULL;
                else if (!accept && retire)
                    count_nxt = EMPTY;
            end
            FULL: begin
                if (retire)
                    count_nxt = ONE;
            end
            default: count_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            core_idx <= '0;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (beat)
                core_idx <= last_core ? '0 : core_idx + IW'(1);
            if (retire)
                rd_ptr <= ~rd_ptr;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Slot payload is qualified by count, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (accept) begin
            slot_data[wr_ptr] <= s_data;
            slot_last[wr_ptr] <= s_last;
            slot_user[wr_ptr] <= s_user;
        end
    end

    // Stale slot contents are masked while the store is empty so the
    // stream reads all-zero when idle and straight out of reset.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tuser = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = slot_data[rd_ptr][core_idx];
            m_axis_tuser = slot_user[rd_ptr];
            m_axis_tlast = slot_last[rd_ptr] & last_core;
        end
    end

endmodule

// File: tb/tb_axis_output_pipe.sv
// Randomized, scoreboard-checked bench for axis_output_pipe.
// Model: a queue of whole blocks, each with a next-core cursor.
module tb_axis_output_pipe;

    localparam int C  = 4;
    localparam int U  = 2;
    localparam int W  = 25;
    localparam int TU = 4;

    typedef logic [C-1:0][U-1:0][W-1:0] blkdata_t;

    typedef struct {
        blkdata_t      data;
        logic [TU-1:0] user;
        logic          last;
        int            core;
    } blk_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              s_valid = 1'b0;
    blkdata_t          s_data = '0;
    logic              s_last = 1'b0;
    logic [TU-1:0]     s_user = '0;
    logic              s_ready;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [U*W-1:0]    m_axis_tdata;
    logic              m_axis_tlast;
    logic [TU-1:0]     m_axis_tuser;
    logic              overflow;

    blk_t mq[$];
    logic m_ovf = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nbeats = 0;
    int   naccept = 0;

    always #5 aclk = ~aclk;

    axis_output_pipe #(
        .CONV_CORES (C),
        .CONV_UNITS (U),
        .WORD_WIDTH (W),
        .TUSER_WIDTH(TU)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_user       (s_user),
        .s_ready      (s_ready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .overflow     (overflow)
    );

    function automatic blk_t mk_blk(int b, logic [TU-1:0] user,
                                    logic last, bit rnd);
        blk_t n;
        for (int c = 0; c < C; c++)
            for (int u = 0; u < U; u++)
                n.data[c][u] = rnd ? W'($urandom)
                                   : W'(16 * c + u + b * 256);
        n.user = user;
        n.last = last;
        n.core = 0;
        return n;
    endfunction

    task automatic drive_blk(blk_t b);
        s_valid = 1'b1;
        s_data  = b.data;
        s_user  = b.user;
        s_last  = b.last;
    endtask

    // Compare outputs to the model, advance the model across the next
    // rising edge, then step to 1 ns after that edge.
    task automatic tick(string tag);
        logic           exp_v;
        logic [U*W-1:0] exp_d;
        logic           exp_l;
        bit             acc;
        blk_t           nb;
        exp_v = (mq.size() != 0);
        checks++;
        if (m_axis_tvalid !== exp_v) begin
            errors++;
            $display("FAIL %s tvalid got %b exp %b", tag,
                     m_axis_tvalid, exp_v);
        end
        checks++;
        if (s_ready !== (mq.size() < 2)) begin
            errors++;
            $display("FAIL %s s_ready got %b exp %b", tag,
                     s_ready, mq.size() < 2);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL %s overflow got %b exp %b", tag,
                     overflow, m_ovf);
        end
        if (exp_v) begin
            exp_d = mq[0].data[mq[0].core];
            exp_l = mq[0].last && (mq[0].core == C - 1);
            checks++;
            if (m_axis_tdata !== exp_d) begin
                errors++;
                $display("FAIL %s tdata got %h exp %h", tag,
                         m_axis_tdata, exp_d);
            end
            checks++;
            if (m_axis_tuser !== mq[0].user) begin
                errors++;
                $display("FAIL %s tuser got %h exp %h", tag,
                         m_axis_tuser, mq[0].user);
            end
            checks++;
            if (m_axis_tlast !== exp_l) begin
                errors++;
                $display("FAIL %s tlast got %b exp %b", tag,
                         m_axis_tlast, exp_l);
            end
        end
        acc = s_valid && (mq.size() < 2);
        if (s_valid && !acc)
            m_ovf = 1'b1;
        if (exp_v && m_axis_tready) begin
            nbeats++;
            mq[0].core = mq[0].core + 1;
            if (mq[0].core == C)
                void'(mq.pop_front());
        end
        if (acc) begin
            naccept++;
            nb.data = s_data;
            nb.user = s_user;
            nb.last = s_last;
            nb.core = 0;
            mq.push_back(nb);
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(string tag);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 200 && mq.size() != 0; i++)
            tick(tag);
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL %s drain timeout left %0d exp 0", tag,
                     mq.size());
        end
        tick(tag);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, overflow, s_ready} !== 4'b0001
            || m_axis_tdata !== '0 || m_axis_tuser !== '0) begin
            errors++;
            $display("FAIL reset outs got v%b l%b o%b r%b d%h u%h exp 0001/0/0",
                     m_axis_tvalid, m_axis_tlast, overflow, s_ready,
                     m_axis_tdata, m_axis_tuser);
        end
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        tick("reset_idle");
    endtask

    task automatic test_single();
        logic [U*W-1:0] first;
        m_axis_tready = 1'b1;
        nbeats = 0;
        drive_blk(mk_blk(0, 4'h5, 1'b1, 1'b0));
        tick("single");
        first = {25'd1, 25'd0};
        checks++;
        if (m_axis_tdata !== first || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL single first got %b/%h exp 1/%h",
                     m_axis_tvalid, m_axis_tdata, first);
        end
        repeat (6) tick("single");
        checks++;
        if (nbeats != 4) begin
            errors++;
            $display("FAIL single beats got %0d exp 4", nbeats);
        end
    endtask

    task automatic test_back_to_back();
        m_axis_tready = 1'b1;
        nbeats = 0;
        drive_blk(mk_blk(0, 4'h1, 1'b0, 1'b0));
        tick("b2b");
        drive_blk(mk_blk(1, 4'h2, 1'b1, 1'b0));
        tick("b2b");
        repeat (10) tick("b2b");
        checks++;
        if (nbeats != 8) begin
            errors++;
            $display("FAIL b2b beats got %0d exp 8", nbeats);
        end
    endtask

    task automatic test_overflow();
        m_axis_tready = 1'b0;
        nbeats = 0;
        for (int b = 0; b < 3; b++) begin
            drive_blk(mk_blk(b, 4'(b + 3), 1'b1, 1'b0));
            tick("ovf_fill");
        end
        repeat (3) tick("ovf_stall");
        drain("ovf_drain");
        checks++;
        if (nbeats != 8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf beats/flag got %0d/%b exp 8/1",
                     nbeats, overflow);
        end
    endtask

    task automatic test_coincident();
        bit sent = 0;
        m_axis_tready = 1'b0;
        nbeats = 0;
        drive_blk(mk_blk(4, 4'h9, 1'b0, 1'b1));
        tick("coin_fill");
        drive_blk(mk_blk(5, 4'hA, 1'b1, 1'b1));
        tick("coin_fill");
        m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!sent && mq.size() == 1 && mq[0].core == C - 1) begin
                drive_blk(mk_blk(6, 4'hB, 1'b1, 1'b1));
                sent = 1;
            end
            tick("coin");
        end
        checks++;
        if (!sent || nbeats != 12) begin
            errors++;
            $display("FAIL coin sent/beats got %0d/%0d exp 1/12",
                     sent, nbeats);
        end
    endtask

    task automatic test_random();
        nbeats = 0;
        naccept = 0;
        for (int b = 0; b < 20; b++) begin
            drive_blk(mk_blk(b, 4'($urandom), 1'($urandom), 1'b1));
            for (int k = 0; k < 6; k++) begin
                m_axis_tready = 1'($urandom_range(0, 1));
                tick("rand");
            end
        end
        drain("rand_drain");
        checks++;
        if (nbeats != naccept * C) begin
            errors++;
            $display("FAIL rand beats got %0d exp %0d", nbeats,
                     naccept * C);
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b1;
        drive_blk(mk_blk(7, 4'h6, 1'b1, 1'b1));
        tick("mid");
        tick("mid");
        tick("mid");
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0
            || m_axis_tdata !== '0) begin
            errors++;
            $display("FAIL mid_reset got v%b o%b d%h exp 0/0/0",
                     m_axis_tvalid, overflow, m_axis_tdata);
        end
        mq.delete();
        m_ovf = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        drive_blk(mk_blk(8, 4'hC, 1'b1, 1'b1));
        tick("mid_fresh");
        drain("mid_fresh");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_coincident();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
